// File: rtl/tx_up_pkg.sv
// Shared types and helpers for the TX I/Q upsampler stream block.
// Mode and state encodings plus the factor lookup used by the output stage.
package tx_up_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'b00,
        HOLD   = 2'b01,
        BYPASS = 2'b10,
        RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    localparam int unsigned RST_LOG2F = 1;

    // Bypass always runs 1:1 regardless of the latched exponent.
    function automatic int unsigned factor_of(input int unsigned log2f, input mode_e mode);
        if (mode == BYPASS) begin
            return 32'd1;
        end
        return 32'd1 << log2f;
    endfunction

endpackage

// File: rtl/tx_up_fifo.sv
// Synchronous FIFO with registered occupancy; pointers wrap modulo DEPTH.
// Push is dropped when full and pop is ignored when empty.
module tx_up_fifo
    import tx_up_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LVW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVW-1:0]   level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVW-1:0]   level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // A simultaneous push and pop cancel out in the occupancy count.
        level_d = level_q + LVW'(push_ok) - LVW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/tx_upsampler_stream.sv
// TX I/Q upsampler: per-stream config latch, input FIFO, slot repeater and
// output register with valid/ready on both sides and in_last framing.
module tx_upsampler_stream
    import tx_up_pkg::*;
#(
    parameter int DW        = 16,
    parameter int DEPTH     = 16,
    parameter int MAX_LOG2F = 4,
    parameter int CNT_W     = 16,
    localparam int LW       = $clog2(MAX_LOG2F + 1),
    localparam int LVW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_i,
    input  logic [DW-1:0]    in_q,
    input  logic             in_last,
    input  logic [1:0]       cfg_mode,
    input  logic [LW-1:0]    cfg_log2f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_i,
    output logic [DW-1:0]    out_q,
    output logic             out_last,
    output logic [CNT_W-1:0] sample_count,
    output logic [LVW-1:0]   buffer_level,
    output logic             busy,
    output logic             cfg_err
);

    localparam int RW = (MAX_LOG2F > 0) ? MAX_LOG2F : 1;
    localparam int FW = 2 * DW + 1;

    // Valid/ready: a beat moves on either side exactly on a clock edge where
    // valid and ready are both high; out_* never change while stalled.

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    mode_e             in_mode;
    logic [LW-1:0]     log2f_q, log2f_d;
    logic              cfg_err_q, cfg_err_d;
    logic              rdy_en_q;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_i_q, out_i_d;
    logic [DW-1:0]     out_q_q, out_q_d;
    logic              out_last_q, out_last_d;
    logic [DW-1:0]     hold_i_q, hold_i_d;
    logic [DW-1:0]     hold_q_q, hold_q_d;
    logic              hold_last_q, hold_last_d;
    logic [RW-1:0]     rep_q, rep_d;
    logic              rep_active_q, rep_active_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [FW-1:0]     fifo_rdata;
    logic [LVW-1:0]    fifo_level;
    logic              f_last;
    logic [DW-1:0]     f_i;
    logic [DW-1:0]     f_q;

    logic              acc;
    logic              idle_acc;
    logic              out_hs;
    logic              load_en;
    logic [RW-1:0]     last_slot;

    assign in_mode   = mode_e'(cfg_mode);
    assign in_ready  = rdy_en_q && (state_q != DRAIN) && !fifo_full;
    assign acc       = in_valid && in_ready;
    assign idle_acc  = acc && (state_q == IDLE);
    assign out_hs    = out_valid_q && out_ready;
    assign load_en   = !out_valid_q || out_ready;
    assign last_slot = RW'(factor_of(32'(log2f_q), mode_q) - 32'd1);
    assign {f_last, f_i, f_q} = fifo_rdata;

    tx_up_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (acc),
        .wdata ({in_last, in_i, in_q}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Stream framing and the per-stream configuration latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        log2f_d   = log2f_q;
        cfg_err_d = cfg_err_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (acc && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (idle_acc) begin
            mode_d  = (in_mode == RSVD) ? ZERO : in_mode;
            log2f_d = (cfg_log2f > LW'(MAX_LOG2F)) ? LW'(MAX_LOG2F) : cfg_log2f;
            if ((in_mode == RSVD) || (cfg_log2f > LW'(MAX_LOG2F))) begin
                cfg_err_d = 1'b1;
            end
        end
        if (idle_acc) begin
            cnt_d = '0;
        end else if (out_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        busy_d = (state_d != IDLE);
    end

    // Output stage: slot 0 pops a fresh sample, later slots replay or zero it.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_i_d      = out_i_q;
        out_q_d      = out_q_q;
        out_last_d   = out_last_q;
        hold_i_d     = hold_i_q;
        hold_q_d     = hold_q_q;
        hold_last_d  = hold_last_q;
        rep_d        = rep_q;
        rep_active_d = rep_active_q;
        fifo_pop     = 1'b0;
        if (load_en) begin
            if (rep_active_q) begin
                out_valid_d  = 1'b1;
                out_i_d      = (mode_q == HOLD) ? hold_i_q : '0;
                out_q_d      = (mode_q == HOLD) ? hold_q_q : '0;
                out_last_d   = hold_last_q && (rep_q == last_slot);
                rep_d        = rep_q + RW'(1);
                rep_active_d = (rep_q != last_slot);
            end else if (!fifo_empty) begin
                fifo_pop     = 1'b1;
                out_valid_d  = 1'b1;
                out_i_d      = f_i;
                out_q_d      = f_q;
                out_last_d   = f_last && (last_slot == '0);
                hold_i_d     = f_i;
                hold_q_d     = f_q;
                hold_last_d  = f_last;
                rep_d        = RW'(1);
                rep_active_d = (last_slot != '0);
            end else begin
                out_valid_d  = 1'b0;
                out_last_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= ZERO;
            log2f_q      <= LW'(RST_LOG2F);
            cfg_err_q    <= 1'b0;
            rdy_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_i_q      <= '0;
            out_q_q      <= '0;
            out_last_q   <= 1'b0;
            hold_i_q     <= '0;
            hold_q_q     <= '0;
            hold_last_q  <= 1'b0;
            rep_q        <= '0;
            rep_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            log2f_q      <= log2f_d;
            cfg_err_q    <= cfg_err_d;
            rdy_en_q     <= 1'b1;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_i_q      <= out_i_d;
            out_q_q      <= out_q_d;
            out_last_q   <= out_last_d;
            hold_i_q     <= hold_i_d;
            hold_q_q     <= hold_q_d;
            hold_last_q  <= hold_last_d;
            rep_q        <= rep_d;
            rep_active_q <= rep_active_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_i        = out_i_q;
    assign out_q        = out_q_q;
    assign out_last     = out_last_q;
    assign sample_count = cnt_q;
    assign buffer_level = fifo_level;
    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_tx_upsampler_stream.sv
// Directed bench for tx_upsampler_stream: table of short streams plus
// hand-written sequences for bypass throughput, backpressure, cfg and reset.
module tb_tx_upsampler_stream;

    localparam int DW = 16;
    localparam int DEPTH = 16;
    localparam int MAX_LOG2F = 4;
    localparam int CNT_W = 16;
    localparam int LW = 3;
    localparam int LVW = 5;
    localparam int NV = 6;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_i;
    logic [DW-1:0]    in_q;
    logic             in_last;
    logic [1:0]       cfg_mode;
    logic [LW-1:0]    cfg_log2f;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_i;
    logic [DW-1:0]    out_q;
    logic             out_last;
    logic [CNT_W-1:0] sample_count;
    logic [LVW-1:0]   buffer_level;
    logic             busy;
    logic             cfg_err;

    typedef struct packed {
        logic        last;
        logic [15:0] i;
        logic [15:0] q;
    } obeat_t;

    typedef struct packed {
        logic [1:0]       mode;
        logic [2:0]       log2f;
        logic [7:0]       nb;
        logic [2:0][15:0] beat;
        logic [7:0]       nout;
        logic [7:0][15:0] exp_i;
        logic             err;
    } vec_t;

    obeat_t      got_q[$];
    vec_t        vec[NV];
    int          checks;
    int          failures;
    int          stable_viol;
    int          max_level;
    int          ready_drops;
    bit          track;
    logic        stall_prev;
    logic [32:0] stall_val;

    tx_upsampler_stream #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .MAX_LOG2F (MAX_LOG2F),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_i         (in_i),
        .in_q         (in_q),
        .in_last      (in_last),
        .cfg_mode     (cfg_mode),
        .cfg_log2f    (cfg_log2f),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_i        (out_i),
        .out_q        (out_q),
        .out_last     (out_last),
        .sample_count (sample_count),
        .buffer_level (buffer_level),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Q is a byte swap of I so zero slots stay zero and held slots are traceable.
    function automatic logic [15:0] q_of(input logic [15:0] i);
        return {i[7:0], i[15:8]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: output handshakes, stall stability, level/ready tracking.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back('{last: out_last, i: out_i, q: out_q});
        end
        if (rst_n && out_valid && !out_ready) begin
            if (stall_prev && ({out_last, out_i, out_q} != stall_val)) begin
                stable_viol++;
            end
            stall_prev = 1'b1;
            stall_val  = {out_last, out_i, out_q};
        end else begin
            stall_prev = 1'b0;
        end
        if (track) begin
            if (int'(buffer_level) > max_level) max_level = int'(buffer_level);
            if (!in_ready) ready_drops++;
        end
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_i      = '0;
        in_q      = '0;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] i, input logic last);
        int   n;
        logic rdy;
        n        = 0;
        in_valid = 1'b1;
        in_i     = i;
        in_q     = q_of(i);
        in_last  = last;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: beat %0h not accepted, required acceptance", i);
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(got_q.size() > 0 && got_q[$].last)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                checks++;
                failures++;
                $display("FAIL stream_done_timeout: got %0d outputs, required out_last", got_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        stable_viol = 0;
        max_level   = 0;
        ready_drops = 0;
        track       = 1'b0;
        stall_prev  = 1'b0;
        stall_val   = '0;
        cfg_mode    = 2'b00;
        cfg_log2f   = 3'd1;

        for (int v = 0; v < NV; v++) vec[v] = '0;
        vec[0].mode = 2'b00; vec[0].log2f = 3'd2; vec[0].nb = 8'd2; vec[0].nout = 8'd8;
        vec[0].beat[0] = 16'h0101; vec[0].beat[1] = 16'h0202;
        vec[0].exp_i[0] = 16'h0101; vec[0].exp_i[4] = 16'h0202;
        vec[1].mode = 2'b01; vec[1].log2f = 3'd1; vec[1].nb = 8'd3; vec[1].nout = 8'd6;
        vec[1].beat[0] = 16'h0A0A; vec[1].beat[1] = 16'h0B0B; vec[1].beat[2] = 16'h0C0C;
        vec[1].exp_i[0] = 16'h0A0A; vec[1].exp_i[1] = 16'h0A0A; vec[1].exp_i[2] = 16'h0B0B;
        vec[1].exp_i[3] = 16'h0B0B; vec[1].exp_i[4] = 16'h0C0C; vec[1].exp_i[5] = 16'h0C0C;
        vec[2].mode = 2'b10; vec[2].log2f = 3'd3; vec[2].nb = 8'd3; vec[2].nout = 8'd3;
        vec[2].beat[0] = 16'h1111; vec[2].beat[1] = 16'h2222; vec[2].beat[2] = 16'h3333;
        vec[2].exp_i[0] = 16'h1111; vec[2].exp_i[1] = 16'h2222; vec[2].exp_i[2] = 16'h3333;
        vec[3].mode = 2'b11; vec[3].log2f = 3'd1; vec[3].nb = 8'd2; vec[3].nout = 8'd4; vec[3].err = 1'b1;
        vec[3].beat[0] = 16'h00AA; vec[3].beat[1] = 16'h00BB;
        vec[3].exp_i[0] = 16'h00AA; vec[3].exp_i[2] = 16'h00BB;
        vec[4].mode = 2'b00; vec[4].log2f = 3'd5; vec[4].nb = 8'd1; vec[4].nout = 8'd16; vec[4].err = 1'b1;
        vec[4].beat[0] = 16'h0555; vec[4].exp_i[0] = 16'h0555;
        vec[5].mode = 2'b01; vec[5].log2f = 3'd0; vec[5].nb = 8'd2; vec[5].nout = 8'd2;
        vec[5].beat[0] = 16'h1234; vec[5].beat[1] = 16'h5678;
        vec[5].exp_i[0] = 16'h1234; vec[5].exp_i[1] = 16'h5678;

        // Reset state, observed both inside and after reset.
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready_low", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        apply_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_level", buffer_level, 0);
        check("rst_busy", busy, 0);
        check("rst_count", sample_count, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_last", out_last, 0);

        // Table-driven streams, each from a fresh reset.
        for (int v = 0; v < NV; v++) begin
            apply_reset();
            got_q.delete();
            cfg_mode  = vec[v].mode;
            cfg_log2f = vec[v].log2f;
            for (int b = 0; b < int'(vec[v].nb); b++) begin
                send_beat(vec[v].beat[b], b == int'(vec[v].nb) - 1);
            end
            idle_inputs();
            wait_done(300);
            check($sformatf("v%0d_nout", v), got_q.size(), vec[v].nout);
            for (int k = 0; k < got_q.size() && k < int'(vec[v].nout); k++) begin
                logic [15:0] ei;
                ei = (k < 8) ? vec[v].exp_i[k] : 16'h0000;
                check($sformatf("v%0d_i%0d", v, k), got_q[k].i, ei);
                check($sformatf("v%0d_q%0d", v, k), got_q[k].q, q_of(ei));
                check($sformatf("v%0d_last%0d", v, k), got_q[k].last, k == int'(vec[v].nout) - 1);
            end
            check($sformatf("v%0d_count", v), sample_count, vec[v].nout);
            check($sformatf("v%0d_busy", v), busy, 0);
            check($sformatf("v%0d_in_ready", v), in_ready, 1);
            check($sformatf("v%0d_cfg_err", v), cfg_err, vec[v].err);
        end

        // Bypass, 20 continuous beats: level stays <=1 and in_ready never drops.
        apply_reset();
        got_q.delete();
        cfg_mode = 2'b10; cfg_log2f = 3'd0;
        max_level = 0; ready_drops = 0; track = 1'b1;
        for (int b = 0; b < 20; b++) send_beat(16'h0100 + 16'(b), b == 19);
        track = 1'b0;
        idle_inputs();
        wait_done(300);
        check("byp_nout", got_q.size(), 20);
        for (int k = 0; k < got_q.size() && k < 20; k++) begin
            check($sformatf("byp_i%0d", k), got_q[k].i, 16'h0100 + 16'(k));
            check($sformatf("byp_last%0d", k), got_q[k].last, k == 19);
        end
        check("byp_level_le1", max_level <= 1, 1);
        check("byp_ready_drops", ready_drops, 0);
        check("byp_count", sample_count, 20);

        // Zero-insert F=16 under 40 cycles of backpressure: FIFO fills, nothing lost.
        apply_reset();
        got_q.delete();
        cfg_mode = 2'b00; cfg_log2f = 3'd4;
        out_ready = 1'b0; stable_viol = 0;
        fork
            begin
                for (int b = 0; b < 20; b++) send_beat(16'hA001 + 16'(b), b == 19);
                idle_inputs();
            end
            begin
                repeat (40) @(posedge clk);
                #1;
                check("bp_level_full", buffer_level, 16);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_out_i_held", out_i, 16'hA001);
                out_ready = 1'b1;
            end
        join
        wait_done(2000);
        check("bp_nout", got_q.size(), 320);
        for (int k = 0; k < got_q.size() && k < 320; k++) begin
            check($sformatf("bp_i%0d", k), got_q[k].i, (k % 16 == 0) ? 16'hA001 + 16'(k / 16) : 16'h0000);
            check($sformatf("bp_last%0d", k), got_q[k].last, k == 319);
        end
        check("bp_stable", stable_viol, 0);
        check("bp_count", sample_count, 320);

        // Config change mid-stream is ignored until the next stream.
        apply_reset();
        got_q.delete();
        cfg_mode = 2'b00; cfg_log2f = 3'd1;
        send_beat(16'h0C01, 1'b0);
        cfg_mode = 2'b01; cfg_log2f = 3'd3;
        send_beat(16'h0C02, 1'b0);
        send_beat(16'h0C03, 1'b1);
        idle_inputs();
        wait_done(300);
        check("cfg_nout", got_q.size(), 6);
        for (int k = 0; k < got_q.size() && k < 6; k++) begin
            check($sformatf("cfg_i%0d", k), got_q[k].i, (k % 2 == 0) ? 16'h0C01 + 16'(k / 2) : 16'h0000);
        end
        got_q.delete();
        send_beat(16'h0D0D, 1'b1);
        idle_inputs();
        wait_done(300);
        check("cfg2_nout", got_q.size(), 8);
        for (int k = 0; k < got_q.size() && k < 8; k++) begin
            check($sformatf("cfg2_i%0d", k), got_q[k].i, 16'h0D0D);
        end
        check("cfg2_count", sample_count, 8);

        // Reset in the middle of a stream with seven beats queued.
        apply_reset();
        got_q.delete();
        cfg_mode = 2'b00; cfg_log2f = 3'd1;
        out_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_beat(16'h0E01 + 16'(b), 1'b0);
        idle_inputs();
        @(negedge clk);
        check("mid_level7", buffer_level, 7);
        check("mid_busy", busy, 1);
        check("mid_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_level", buffer_level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", sample_count, 0);
        check("mid_rst_out_i", out_i, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        send_beat(16'h0E55, 1'b1);
        idle_inputs();
        wait_done(300);
        check("post_nout", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("post_i0", got_q[0].i, 16'h0E55);
            check("post_i1", got_q[1].i, 16'h0000);
        end
        check("post_count", sample_count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
